// File: rtl/ex_alu_pkg.sv
// Shared types and constants for the execute-stage ALU: opcodes, control states, flag bit positions.
package ex_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NAND = 4'd2,
      OP_XOR  = 4'd3,
      OP_NOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_MUL  = 4'd8
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/ex_alu_pipe_if.sv
// Request/response bundle between the ID/EX register (master) and the execute ALU (slave).
interface ex_alu_pipe_if #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   shamt;
   logic [2:0]       flag_we;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             neg;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, op, a, b, shamt, flag_we, out_ready,
      input  in_ready, out_valid, result, zero, neg, ovf, busy
   );

   modport slave (
      input  in_valid, op, a, b, shamt, flag_we, out_ready,
      output in_ready, out_valid, result, zero, neg, ovf, busy
   );
endinterface

// File: rtl/ex_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module ex_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             prod_hi_nz
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic                 run_q, run_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_step;

   always_comb begin
      run_d    = run_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (start) begin
         run_d    = 1'b1;
         cnt_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
      end else if (run_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (cnt_q == LAST) run_d = 1'b0;
      end
   end

   // The final product is taken from the last step's sum so it lands on the same edge as done.
   assign done       = run_q && (cnt_q == LAST);
   assign prod_lo    = acc_step[WIDTH-1:0];
   assign prod_hi_nz = |acc_step[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

endmodule

// File: rtl/ex_alu_pipe.sv
// Registered execute-stage ALU with valid/ready on both sides and an iterative multiply.
module ex_alu_pipe
   import ex_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          rst_n,
   ex_alu_pipe_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       flags_q, flags_d;
   logic [2:0]       fwe_q, fwe_d;
   logic             in_ready, accept, mul_start;
   logic             mul_done, mul_hi_nz;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   alu_out;

   function automatic logic [WIDTH:0] alu_eval(logic [3:0] op, logic [WIDTH-1:0] x,
                                              logic [WIDTH-1:0] y, logic [SHW-1:0] sh);
      logic [WIDTH-1:0]        r;
      logic signed [WIDTH-1:0] xs;
      logic                    v;
      r  = '0;
      v  = 1'b0;
      xs = x;
      case (op)
         OP_ADD:  begin r = x + y; v = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]); end
         OP_SUB:  begin r = x - y; v = (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]); end
         OP_NAND: r = ~(x & y);
         OP_XOR:  r = x ^ y;
         OP_NOR:  r = ~(x | y);
         OP_SLL:  r = x << sh;
         OP_SRL:  r = x >> sh;
         OP_SRA:  r = xs >>> sh;
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   function automatic logic [2:0] flags_of(logic [WIDTH-1:0] r, logic v);
      logic [2:0] f;
      f            = '0;
      f[FLAG_ZERO] = ~|r;
      f[FLAG_NEG]  = r[MSB];
      f[FLAG_OVF]  = v;
      return f;
   endfunction

   function automatic logic [2:0] merge_flags(logic [2:0] cur, logic [2:0] nxt, logic [2:0] we);
      return (cur & ~we) | (nxt & we);
   endfunction

   assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign alu_out  = alu_eval(bus.op, bus.a, bus.b, bus.shamt);

   ex_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (mul_start),
      .a          (bus.a),
      .b          (bus.b),
      .done       (mul_done),
      .prod_lo    (mul_lo),
      .prod_hi_nz (mul_hi_nz)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      flags_d   = flags_q;
      fwe_d     = fwe_q;
      mul_start = 1'b0;
      if ((state_q == MUL_RUN) && mul_done) begin
         state_d  = HOLD;
         result_d = mul_lo;
         flags_d  = merge_flags(flags_q, flags_of(mul_lo, mul_hi_nz), fwe_q);
      end else if ((state_q == HOLD) && bus.out_ready) begin
         state_d = IDLE;
      end
      // A new accept overrides the drain above; illegal opcodes yield 0 and leave the flags alone.
      if (accept) begin
         if (bus.op == OP_MUL) begin
            state_d   = MUL_RUN;
            mul_start = 1'b1;
            fwe_d     = bus.flag_we;
         end else begin
            state_d  = HOLD;
            result_d = alu_out[WIDTH-1:0];
            if (bus.op < OP_MUL)
               flags_d = merge_flags(flags_q, flags_of(alu_out[WIDTH-1:0], alu_out[WIDTH]),
                                     bus.flag_we);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
         fwe_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         fwe_q    <= fwe_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.busy      = (state_q == MUL_RUN);
   assign bus.result    = result_q;
   assign bus.zero      = flags_q[FLAG_ZERO];
   assign bus.neg       = flags_q[FLAG_NEG];
   assign bus.ovf       = flags_q[FLAG_OVF];

endmodule

// File: doc/ex_alu_pipe.md
# ex_alu_pipe

Registered, width-parametrised execute-stage ALU for the 5-stage pipeline. It supersedes the purely combinational 16-bit ALU. It adds a valid/ready handshake on both sides, a registered result and flag register, and a multi-cycle iterative multiply. It sits between the ID/EX pipeline register and the EX/MEM stage, and stalls the front end through `in_ready` while a multiply is in flight or the output is blocked.

## Interface
- `WIDTH`, 16: datapath width in bits; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `op`  in  4  `alu_op_t` opcode.
- `a`, `b`  in  WIDTH each  operands.
- `shamt`  in  SHW  shift amount for SLL/SRL/SRA.
- `flag_we`  in  3  per-flag update mask {ovf, neg, zero}, captured with the request.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  downstream consumes `result`.
- `result`  out  WIDTH  registered result.
- `zero`, `neg`, `ovf`  out  1 each  flag register (architectural condition codes).
- `busy`  out  1  multiply in progress.

## Operation
- Opcodes (4 bits): ADD=0, SUB=1, NAND=2, XOR=3, NOR=4, SLL=5, SRL=6, SRA=7, MUL=8. Codes 9–15 are illegal.
- All arithmetic is modulo 2^WIDTH. SRA is an arithmetic shift, replicating `a[WIDTH-1]`.
- An illegal opcode is accepted and completes in 1 cycle with `result`=0. Its flags are not updated, regardless of `flag_we`.
- Flags are computed on the final result:
  - zero = ~|result.
  - neg = result[WIDTH-1].
  - ovf for ADD: operands share a sign and the result sign differs.
  - ovf for SUB: uses the inverted sign of b, so a − 0x8000 (at WIDTH=16) is judged correctly.
  - ovf for MUL: the unsigned product's upper WIDTH bits are nonzero.
  - ovf for logic and shift ops: 0.
- Each flag bit loads only if its `flag_we` bit was set when the request was accepted. Flags load on the same edge that raises `out_valid`.
- MUL is an unsigned shift-add over WIDTH iterations and returns the low WIDTH bits.
- States:
  - IDLE: no result held.
  - MUL_RUN: multiply iterating.
  - HOLD: result held, waiting for downstream.
- Transitions:
  - IDLE → HOLD: on accept of a non-MUL op.
  - IDLE → MUL_RUN: on accept of MUL.
  - MUL_RUN → HOLD: when the iteration counter reaches WIDTH−1.
  - HOLD → IDLE: on out_ready with no new accept.
  - HOLD → HOLD or MUL_RUN: on out_ready with a simultaneous accept.
- `in_ready` = (state==IDLE) | (state==HOLD & out_ready). A held result and a new accept on the same edge is a legal back-to-back transfer.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `neg`=0, `ovf`=0, `busy`=0. State is IDLE and the iteration counter is 0.
- Non-MUL latency: 1 cycle. Accept at edge N; `out_valid`=1 after edge N.
- MUL latency: WIDTH cycles. Accept at edge N; `busy`=1 for WIDTH cycles; `out_valid`=1 after edge N+WIDTH. `in_ready`=0 throughout.
- Throughput: 1 non-MUL op per cycle while `out_ready` stays high.
- `result` and the flags stay stable while `out_valid & !out_ready`.
- Asserting `rst_n` mid-MUL aborts the multiply and forces the reset values immediately. No partial result is ever presented.
- `in_valid` while `in_ready`=0 is ignored. The requester holds its inputs.

## Structure
- Package `ex_alu_pkg` holds:
  - the `alu_op_t` enum (4-bit),
  - the `state_t` enum {IDLE, MUL_RUN, HOLD},
  - the flag-index constants FLAG_ZERO=0, FLAG_NEG=1, FLAG_OVF=2.
- Sub-module `ex_mul_iter` (parameter WIDTH):
  - ports `start`, `a`, `b`, `done`, `prod_lo`, `prod_hi_nz`,
  - holds the counter, the multiplicand shift register and the 2·WIDTH accumulator,
  - shares `clk`/`rst_n`.
- The top level holds the combinational single-cycle ALU, the control FSM, and the result and flag registers.

## Test plan
- WIDTH=16, `out_ready`=1, back-to-back ADD 0x7FFF+0x0001 then SUB 0x0000−0x8000, `flag_we`=7 → results 0x8000 and 0x8000 on consecutive cycles; ovf=1 both; neg=1 both.
- SRA a=0x8004, shamt=2 → 0xE001, neg=1. SRL on the same inputs → 0x2001, neg=0. `flag_we`=0b001 → only zero updates.
- MUL 0x0100×0x0100 → `busy` for 16 cycles, `in_ready`=0, then result 0x0000, zero=1, ovf=1. MUL 0x00FF×0x0003 → 0x02FD, ovf=0.
- `out_ready`=0 for 5 cycles after an XOR result → result and flags stable, `in_ready`=0. Raise `out_ready` together with a new `in_valid` → new op accepted on that edge.
- Drop `rst_n` at MUL cycle 7 → all outputs return to their reset values. After release, ADD 1+1 → 0x0002 after 1 cycle.
- WIDTH=32 with illegal op 0xF → result 0, flags unchanged, 1-cycle completion.
